bird_motion_ctrl: RTL and testbench

Parametrised bird controller for the flappy-bird game datapath. It combines the game-flow state machine with a vertical physics engine: signed velocity, gravity, flap impulse, floor and ceiling limits, collision stop and a pipe score counter. Physics advances once per frame on `frame_tick`. Outputs drive the VGA draw logic and the score/HEX display.

---
 rtl/bird_motion_ctrl.sv | 124 ++++++++++++
 tb/tb_bird_motion_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bird_motion_ctrl.sv
// bird_motion_ctrl: flappy-bird game FSM with per-frame vertical physics and pipe score
module bird_motion_ctrl #(
  parameter int Y_WIDTH     = 9,
  parameter int Y_MAX       = 400,
  parameter int Y_START     = 200,
  parameter int VEL_WIDTH   = 6,
  parameter int FLAP_VEL    = 8,
  parameter int GRAVITY     = 1,
  parameter int VEL_MAX     = 12,
  parameter int HOLD_TICKS  = 60,
  parameter int SCORE_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   press_key,
  input  logic                   touched,
  input  logic                   frame_tick,
  input  logic                   pipe_pass,
  output logic [2:0]             state,
  output logic [Y_WIDTH-1:0]     bird_y,
  output logic [VEL_WIDTH-1:0]   bird_vel,
  output logic [SCORE_WIDTH-1:0] score,
  output logic                   playing,
  output logic                   game_over
);
  typedef enum logic [2:0] {READY = 3'd0, START = 3'd1, RISING = 3'd2, FALLING = 3'd3, STOP = 3'd4} state_t;
  localparam int HW = $clog2(HOLD_TICKS + 2);
  localparam logic [Y_WIDTH-1:0] YS = Y_WIDTH'(Y_START);
  localparam logic [Y_WIDTH-1:0] YM = Y_WIDTH'(Y_MAX);
  localparam logic signed [Y_WIDTH+1:0] Y_TOP = (Y_WIDTH+2)'(Y_MAX);
  localparam logic [VEL_WIDTH-1:0] VF = VEL_WIDTH'(FLAP_VEL);
  localparam logic signed [VEL_WIDTH:0] V_FLAP = (VEL_WIDTH+1)'(FLAP_VEL);
  localparam logic signed [VEL_WIDTH:0] V_GRAV = (VEL_WIDTH+1)'(GRAVITY);
  localparam logic signed [VEL_WIDTH:0] V_MIN = (VEL_WIDTH+1)'(-VEL_MAX);
  localparam logic [HW-1:0] HT = HW'(HOLD_TICKS);
  state_t st, st_n;
  logic press_q, pend, pend_n, flap, play, y_le0, y_top;
  logic [Y_WIDTH-1:0] y_nx;
  logic [VEL_WIDTH-1:0] v_nx;
  logic [SCORE_WIDTH-1:0] sc_nx;
  logic [HW-1:0] hold, h_nx;
  logic signed [Y_WIDTH+1:0] y_sum, vel_x;
  logic signed [VEL_WIDTH:0] vel_w, v_dec, v_ph;
  assign state = st;
  assign flap = press_key & ~press_q;
  assign play = st == RISING || st == FALLING;
  assign vel_x = (Y_WIDTH+2)'($signed(bird_vel));
  assign y_sum = $signed({2'b00, bird_y}) + vel_x;
  assign y_le0 = y_sum[Y_WIDTH+1] | ~|y_sum;
  assign y_top = y_sum >= Y_TOP;
  assign vel_w = (VEL_WIDTH+1)'($signed(bird_vel));
  assign v_dec = vel_w - V_GRAV;
  assign v_ph = pend ? V_FLAP : (v_dec < V_MIN ? V_MIN : v_dec);
  always_comb begin
    st_n = st;
    y_nx = bird_y;
    v_nx = bird_vel;
    sc_nx = score;
    h_nx = hold;
    pend_n = (flap & play) ? 1'b1 : (frame_tick ? 1'b0 : pend);
    case (st)
      READY: if (flap) begin
        st_n = START;
        v_nx = VF;
        sc_nx = '0;
        pend_n = 1'b0;
      end
      START: st_n = RISING;
      RISING, FALLING: begin
        if (pipe_pass & ~touched & ~&score) sc_nx = score + SCORE_WIDTH'(1);
        if (touched) begin
          st_n = STOP;
          h_nx = HT;
        end else if (frame_tick) begin
          if (y_le0) begin
            y_nx = '0;
            v_nx = '0;
            st_n = STOP;
            h_nx = HT;
          end else begin
            y_nx = y_top ? YM : y_sum[Y_WIDTH-1:0];
            v_nx = (y_top & ~v_ph[VEL_WIDTH]) ? '0 : v_ph[VEL_WIDTH-1:0];
            st_n = (~v_nx[VEL_WIDTH-1] & |v_nx) ? RISING : FALLING;
          end
        end
      end
      STOP: if (frame_tick) begin
        if (hold == '0) begin
          st_n = READY;
          y_nx = YS;
          v_nx = '0;
        end else h_nx = hold - HW'(1);
      end
      default: begin
        st_n = READY;
        y_nx = YS;
        v_nx = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st <= READY;
      bird_y <= YS;
      bird_vel <= '0;
      score <= '0;
      hold <= '0;
      pend <= 1'b0;
      press_q <= 1'b0;
      playing <= 1'b0;
      game_over <= 1'b0;
    end else begin
      st <= st_n;
      bird_y <= y_nx;
      bird_vel <= v_nx;
      score <= sc_nx;
      hold <= h_nx;
      pend <= pend_n;
      press_q <= press_key;
      playing <= st_n == RISING || st_n == FALLING;
      game_over <= st_n == STOP;
    end
  end
endmodule

// File: tb/tb_bird_motion_ctrl.sv
// tb_bird_motion_ctrl: scenario tasks plus randomized run against a cycle-level behavioural model
module tb_bird_motion_ctrl;
  localparam int YS = 200, YM = 400, FV = 8, GR = 1, VM = 12, HT = 2, SMAX = 3;
  logic clk = 0, reset = 1, press_key = 0, touched = 0, frame_tick = 0, pipe_pass = 0;
  logic [2:0] state;
  logic [8:0] bird_y;
  logic [5:0] bird_vel;
  logic [1:0] score;
  logic playing, game_over;
  int checks = 0, errors = 0;
  int ms = 0, my = 0, mv = 0, msc = 0, mpend = 0, mkq = 0, mhold = 0;
  wire [21:0] dut_vec = {state, bird_y, bird_vel, score, playing, game_over};
  always #5 clk = ~clk;
  bird_motion_ctrl #(.HOLD_TICKS(HT), .SCORE_WIDTH(2)) dut (
    .clk(clk), .reset(reset), .press_key(press_key), .touched(touched),
    .frame_tick(frame_tick), .pipe_pass(pipe_pass), .state(state), .bird_y(bird_y),
    .bird_vel(bird_vel), .score(score), .playing(playing), .game_over(game_over));

  function automatic logic [21:0] exp_vec();
    return {ms[2:0], my[8:0], mv[5:0], msc[1:0], ms == 2 || ms == 3, ms == 4};
  endfunction

  task automatic model_step();
    int ns, ny, nv, nsc, nh, np, yn, vn;
    bit fe, pl;
    fe = press_key && !mkq;
    pl = ms == 2 || ms == 3;
    ns = ms; ny = my; nv = mv; nsc = msc; nh = mhold;
    np = (fe && pl) ? 1 : (frame_tick ? 0 : mpend);
    if (reset) begin
      ns = 0; ny = YS; nv = 0; nsc = 0; np = 0; nh = 0;
    end else if (ms == 0) begin
      if (fe) begin ns = 1; nv = FV; nsc = 0; np = 0; end
    end else if (ms == 1) ns = 2;
    else if (pl) begin
      if (pipe_pass && !touched) nsc = msc < SMAX ? msc + 1 : SMAX;
      if (touched) begin ns = 4; nh = HT; end
      else if (frame_tick) begin
        yn = my + mv;
        vn = mpend ? FV : ((mv - GR < -VM) ? -VM : mv - GR);
        if (yn <= 0) begin ny = 0; nv = 0; ns = 4; nh = HT; end
        else if (yn >= YM) begin ny = YM; nv = vn < 0 ? vn : 0; ns = nv > 0 ? 2 : 3; end
        else begin ny = yn; nv = vn; ns = nv > 0 ? 2 : 3; end
      end
    end else if (ms == 4 && frame_tick) begin
      if (mhold == 0) begin ns = 0; ny = YS; nv = 0; end
      else nh = mhold - 1;
    end
    mkq = reset ? 0 : press_key;
    ms = ns; my = ny; mv = nv; msc = nsc; mhold = nh; mpend = np;
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1;
    cyc();
    frame_tick = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    cyc();
    cyc();
    reset = 0;
    checks++;
    if (dut_vec !== {3'd0, 9'd200, 6'd0, 2'd0, 1'b0, 1'b0})
      $display("FAIL reset_const dut=%h exp=%h", dut_vec, {3'd0, 9'd200, 6'd0, 2'd0, 1'b0, 1'b0});
    if (dut_vec !== {3'd0, 9'd200, 6'd0, 2'd0, 1'b0, 1'b0}) errors++;
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_model dut=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_rise_fall();
    press_key = 1;
    cyc();
    press_key = 0;
    checks++;
    if ({state, bird_vel, score} !== {3'd1, 6'd8, 2'd0}) begin
      errors++; $display("FAIL start_state dut=%h exp=%h", {state, bird_vel, score}, {3'd1, 6'd8, 2'd0});
    end
    cyc();
    checks++;
    if (state !== 3'd2 || playing !== 1'b1) begin errors++; $display("FAIL start_exit state=%0d exp=2", state); end
    for (int t = 1; t <= 35; t++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL fall_tick%0d dut=%h exp=%h", t, dut_vec, exp_vec()); end
      if (t == 8) begin
        checks++;
        if ({bird_y, bird_vel, state} !== {9'd236, 6'd0, 3'd3}) begin
          errors++; $display("FAIL apex y=%0d v=%0d st=%0d exp y=236 v=0 st=3", bird_y, $signed(bird_vel), state);
        end
      end
      if (t == 20 || t == 30) begin
        checks++;
        if (bird_vel !== 6'h34) begin errors++; $display("FAIL vel_clamp v=%0d exp=-12", $signed(bird_vel)); end
      end
      if (t == 34) begin
        checks++;
        if ({bird_y, state} !== {9'd2, 3'd3}) begin errors++; $display("FAIL pre_floor y=%0d st=%0d exp y=2 st=3", bird_y, state); end
      end
      if (t == 35) begin
        checks++;
        if ({bird_y, bird_vel, state, game_over, playing} !== {9'd0, 6'd0, 3'd4, 1'b1, 1'b0}) begin
          errors++; $display("FAIL floor y=%0d st=%0d go=%0d exp y=0 st=4 go=1", bird_y, state, game_over);
        end
      end
      repeat ($urandom_range(0, 3)) cyc();
    end
  endtask

  task automatic test_hold_expiry();
    for (int t = 1; t <= 3; t++) begin
      press_key = (t == 1);
      cyc();
      press_key = 0;
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL hold_tick%0d dut=%h exp=%h", t, dut_vec, exp_vec()); end
      checks++;
      if (t < 3 && state !== 3'd4) begin errors++; $display("FAIL hold_stay%0d st=%0d exp=4", t, state); end
      else if (t == 3 && {state, bird_y, bird_vel, game_over} !== {3'd0, 9'd200, 6'd0, 1'b0}) begin
        errors++; $display("FAIL hold_ready st=%0d y=%0d exp st=0 y=200", state, bird_y);
      end
    end
  endtask

  task automatic test_held_key();
    press_key = 1;
    for (int c = 0; c < 50; c++) begin
      frame_tick = (c % 4 == 3);
      cyc();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL held_c%0d dut=%h exp=%h", c, dut_vec, exp_vec()); end
    end
    frame_tick = 0;
    checks++;
    if ({state, bird_y, bird_vel} !== {3'd3, 9'd230, 6'h3C}) begin
      errors++; $display("FAIL held_one_flap st=%0d y=%0d v=%0d exp st=3 y=230 v=-4", state, bird_y, $signed(bird_vel));
    end
    press_key = 0;
    cyc();
    press_key = 1;
    cyc();
    press_key = 0;
    tick();
    checks++;
    if ({state, bird_y, bird_vel} !== {3'd2, 9'd226, 6'd8}) begin
      errors++; $display("FAIL reflap st=%0d y=%0d v=%0d exp st=2 y=226 v=8", state, bird_y, $signed(bird_vel));
    end
    tick();
    checks++;
    if ({bird_y, bird_vel} !== {9'd234, 6'd7}) begin
      errors++; $display("FAIL reflap_once y=%0d v=%0d exp y=234 v=7", bird_y, $signed(bird_vel));
    end
  endtask

  task automatic test_touched();
    logic [8:0] y0;
    logic [5:0] v0;
    repeat (2) begin pipe_pass = 1; cyc(); pipe_pass = 0; cyc(); end
    checks++;
    if (score !== 2'd2) begin errors++; $display("FAIL score_two score=%0d exp=2", score); end
    y0 = bird_y;
    v0 = bird_vel;
    touched = 1; pipe_pass = 1; frame_tick = 1;
    cyc();
    touched = 0; pipe_pass = 0; frame_tick = 0;
    checks++;
    if ({state, game_over, playing, score, bird_y, bird_vel} !== {3'd4, 1'b1, 1'b0, 2'd2, y0, v0}) begin
      errors++; $display("FAIL touched st=%0d sc=%0d y=%0d exp st=4 sc=2 y=%0d", state, score, bird_y, y0);
    end
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL touched_model dut=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_score_sat();
    press_key = 1;
    cyc();
    press_key = 0;
    checks++;
    if ({state, score} !== {3'd1, 2'd0}) begin errors++; $display("FAIL start_clr st=%0d sc=%0d exp st=1 sc=0", state, score); end
    cyc();
    repeat (5) begin pipe_pass = 1; cyc(); pipe_pass = 0; cyc(); end
    checks++;
    if (score !== 2'd3) begin errors++; $display("FAIL score_sat score=%0d exp=3", score); end
    checks++;
    if (dut_vec !== exp_vec()) begin errors++; $display("FAIL sat_model dut=%h exp=%h", dut_vec, exp_vec()); end
  endtask

  task automatic test_reset_mid();
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL mid_pre st=%0d exp=2", state); end
    reset = 1;
    cyc();
    reset = 0;
    checks++;
    if (dut_vec !== {3'd0, 9'd200, 6'd0, 2'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_mid dut=%h exp=%h", dut_vec, {3'd0, 9'd200, 6'd0, 2'd0, 1'b0, 1'b0});
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) press_key = ~press_key;
      frame_tick = $urandom_range(0, 2) == 0;
      pipe_pass = $urandom_range(0, 7) == 0;
      touched = $urandom_range(0, 59) == 0;
      reset = $urandom_range(0, 699) == 0;
      cyc();
      checks++;
      if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random_c%0d dut=%h exp=%h", c, dut_vec, exp_vec()); end
    end
    {press_key, frame_tick, pipe_pass, touched, reset} = '0;
  endtask

  initial begin
    test_reset();
    test_rise_fall();
    test_hold_expiry();
    test_held_key();
    test_touched();
    test_hold_expiry();
    test_score_sat();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
